// File: rtl/rx_zc_pkg.sv
// -----------------------------------------------------------------------------
// rx_zc_pkg
// Shared definitions for the RX ZC reference-phase generator.
//   PHASE_WIDTH_DEF : default width of phase index and modulus M = 24*Nzc
//   LEN_WIDTH_DEF   : default width of Nzc and sequence length
//   ZC_MOD_MUL      : M = ZC_MOD_MUL * Nzc (phase unit pi/(12*Nzc))
//   zc_state_e      : generator FSM states
// -----------------------------------------------------------------------------
package rx_zc_pkg;

    localparam int PHASE_WIDTH_DEF = 16;
    localparam int LEN_WIDTH_DEF   = 11;
    localparam int ZC_MOD_MUL      = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } zc_state_e;

endpackage

// File: rtl/zc_mod_add.sv
// -----------------------------------------------------------------------------
// zc_mod_add
// Combinational modular adder: sum = (a + b) mod m, valid for a, b < m.
// The raw sum is held one bit wider so a single conditional subtract suffices.
//   a, b : operands, each < m
//   m    : modulus
//   sum  : (a + b) mod m
// -----------------------------------------------------------------------------
module zc_mod_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] sum
);

    logic [W:0] raw;
    logic [W:0] red;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        red = raw - {1'b0, m};
        sum = (raw >= {1'b0, m}) ? red[W-1:0] : raw[W-1:0];
    end

endmodule

// File: rtl/rx_zc_phase_gen.sv
// -----------------------------------------------------------------------------
// rx_zc_phase_gen
// Streams the per-sample reference phase index of a local ZC sequence:
//   phase(n) = (Q*m*(m+1) + P*n) mod M,  m = n mod Nzc,  M = 24*Nzc
// computed recursively with modular adders only (no multipliers).
//
// Ports:
//   sys_clk, rst_n         : clock, async active-low reset
//   zc_N_zc, zc_Q, zc_P,
//   seq_len                : configuration, latched on an accepted start
//   start                  : one-cycle request, ignored unless idle
//   busy                   : run in progress (cleared in the done cycle)
//   done                   : one-cycle pulse after the last transfer
//   phase, phase_valid,
//   phase_ready            : output stream, transfer on valid && ready
//
// Build option: define RX_ZC_CONJ_EN to emit the conjugate phase
// (M - phase) mod M instead; latency is unchanged.
// -----------------------------------------------------------------------------
module rx_zc_phase_gen
    import rx_zc_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int LEN_WIDTH   = LEN_WIDTH_DEF
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic [LEN_WIDTH-1:0]   zc_N_zc,
    input  logic [14:0]            zc_Q,
    input  logic [PHASE_WIDTH-1:0] zc_P,
    input  logic [LEN_WIDTH-1:0]   seq_len,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   phase_valid,
    input  logic                   phase_ready
);

    zc_state_e state;

    // latched configuration
    logic [LEN_WIDTH-1:0]   nzc_r;
    logic [LEN_WIDTH-1:0]   len_r;
    logic [PHASE_WIDTH-1:0] q_r;
    logic [PHASE_WIDTH-1:0] p_r;
    logic [PHASE_WIDTH-1:0] mod_r;
    logic [PHASE_WIDTH-1:0] two_q_r;

    // run accumulators
    logic [PHASE_WIDTH-1:0] t_r;
    logic [PHASE_WIDTH-1:0] d_r;
    logic [PHASE_WIDTH-1:0] s_r;
    logic [LEN_WIDTH-1:0]   n_r;
    logic [LEN_WIDTH-1:0]   m_r;

    // combinational datapath
    logic [PHASE_WIDTH-1:0] nzc_ext;
    logic [PHASE_WIDTH-1:0] mod_calc;
    logic [PHASE_WIDTH-1:0] two_q_c;
    logic [PHASE_WIDTH-1:0] t_add;
    logic [PHASE_WIDTH-1:0] d_add;
    logic [PHASE_WIDTH-1:0] s_next;
    logic [PHASE_WIDTH-1:0] t_next;
    logic [PHASE_WIDTH-1:0] d_next;
    logic [PHASE_WIDTH-1:0] ph_sum;
    logic [PHASE_WIDTH-1:0] ph_out;
    logic                   m_wrap;
    logic                   last;
    logic                   xfer;

    // M = 16*Nzc + 8*Nzc; fits PHASE_WIDTH for Nzc <= 2047
    assign nzc_ext  = PHASE_WIDTH'(nzc_r);
    assign mod_calc = (nzc_ext << 4) + (nzc_ext << 3);

    // 2Q mod M, evaluated in INIT against the freshly computed modulus
    zc_mod_add #(.W(PHASE_WIDTH)) u_two_q (
        .a   (q_r),
        .b   (q_r),
        .m   (mod_calc),
        .sum (two_q_c)
    );

    zc_mod_add #(.W(PHASE_WIDTH)) u_t_acc (
        .a   (t_r),
        .b   (d_r),
        .m   (mod_r),
        .sum (t_add)
    );

    zc_mod_add #(.W(PHASE_WIDTH)) u_d_acc (
        .a   (d_r),
        .b   (two_q_r),
        .m   (mod_r),
        .sum (d_add)
    );

    zc_mod_add #(.W(PHASE_WIDTH)) u_s_acc (
        .a   (s_r),
        .b   (p_r),
        .m   (mod_r),
        .sum (s_next)
    );

    // ZC term restarts every Nzc samples; the cyclic-shift term keeps running
    assign m_wrap = (m_r == nzc_r - LEN_WIDTH'(1));
    assign t_next = m_wrap ? '0      : t_add;
    assign d_next = m_wrap ? two_q_r : d_add;

    // phase of the next sample, from the already-advanced accumulators
    zc_mod_add #(.W(PHASE_WIDTH)) u_out_sum (
        .a   (t_next),
        .b   (s_next),
        .m   (mod_r),
        .sum (ph_sum)
    );

`ifdef RX_ZC_CONJ_EN
    assign ph_out = (ph_sum == '0) ? '0 : (mod_r - ph_sum);
`else
    assign ph_out = ph_sum;
`endif

    assign last = (n_r == len_r - LEN_WIDTH'(1));
    assign xfer = (state == ST_RUN) && phase_valid && phase_ready;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            nzc_r       <= '0;
            len_r       <= '0;
            q_r         <= '0;
            p_r         <= '0;
            mod_r       <= '0;
            two_q_r     <= '0;
            t_r         <= '0;
            d_r         <= '0;
            s_r         <= '0;
            n_r         <= '0;
            m_r         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            phase       <= '0;
            phase_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        nzc_r <= zc_N_zc;
                        len_r <= seq_len;
                        q_r   <= PHASE_WIDTH'(zc_Q);
                        p_r   <= zc_P;
                        busy  <= 1'b1;
                        state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    mod_r       <= mod_calc;
                    two_q_r     <= two_q_c;
                    d_r         <= two_q_c;
                    t_r         <= '0;
                    s_r         <= '0;
                    n_r         <= '0;
                    m_r         <= '0;
                    // phase(0) is always 0, and so is its conjugate
                    phase       <= '0;
                    phase_valid <= 1'b1;
                    state       <= ST_RUN;
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (last) begin
                            phase_valid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            t_r   <= t_next;
                            d_r   <= d_next;
                            s_r   <= s_next;
                            n_r   <= n_r + LEN_WIDTH'(1);
                            m_r   <= m_wrap ? '0 : (m_r + LEN_WIDTH'(1));
                            phase <= ph_out;
                        end
                    end
                end
                ST_DONE: begin
                    // start is deliberately not sampled here
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_zc_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_rx_zc_phase_gen
// Scoreboard bench: each run pushes the expected phase stream into exp_q; an
// independent monitor pops and compares on every valid && ready transfer.
// Honours RX_ZC_CONJ_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_rx_zc_phase_gen;
    import rx_zc_pkg::*;

    localparam int PW = 16;
    localparam int LW = 11;

    logic          sys_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic [LW-1:0] zc_N_zc = '0;
    logic [14:0]   zc_Q    = '0;
    logic [PW-1:0] zc_P    = '0;
    logic [LW-1:0] seq_len = '0;
    logic          start   = 1'b0;
    logic          busy;
    logic          done;
    logic [PW-1:0] phase;
    logic          phase_valid;
    logic          phase_ready = 1'b1;

    rx_zc_phase_gen #(.PHASE_WIDTH(PW), .LEN_WIDTH(LW)) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .zc_N_zc     (zc_N_zc),
        .zc_Q        (zc_Q),
        .zc_P        (zc_P),
        .seq_len     (seq_len),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .phase       (phase),
        .phase_valid (phase_valid),
        .phase_ready (phase_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int            checks = 0;
    int            errors = 0;
    int            xfers  = 0;
    int            dones  = 0;
    int            cur_m  = 120;
    bit            rand_ready = 1'b0;
    bit            hold_pend  = 1'b0;
    logic [PW-1:0] hold_val   = '0;
    logic [PW-1:0] exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int model(input int n, input int nzc, input int q, input int p);
        longint mm, m, t, s, r;
        mm = longint'(ZC_MOD_MUL) * nzc;
        m  = n % nzc;
        t  = (longint'(q) * m * (m + 1)) % mm;
        s  = (longint'(p) * n) % mm;
        r  = (t + s) % mm;
`ifdef RX_ZC_CONJ_EN
        r  = (mm - r) % mm;
`endif
        return int'(r);
    endfunction

    task automatic push_vec(input int v[]);
        foreach (v[i]) exp_q.push_back(PW'(v[i]));
    endtask

    // ready driver: changes just after the active edge
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            phase_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: samples on the falling edge, before the transfer edge
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend && phase_valid)
                    chk("hold_stable", phase, hold_val);
                if (phase_valid)
                    chk("phase_below_m", longint'(phase < PW'(cur_m)), 1);
                if (phase_valid && phase_ready) begin
                    if (exp_q.size() == 0)
                        chk("unexpected_xfer", phase, -1);
                    else
                        chk("phase", phase, exp_q.pop_front());
                    xfers++;
                end
                hold_pend = phase_valid && !phase_ready;
                hold_val  = phase;
                if (done) dones++;
            end
        end
    end

    task automatic run(input int nzc, input int q, input int p, input int len,
                       input bit rnd, input bit poke, input bit start_on_done);
        bit seen;
        rand_ready = rnd;
        cur_m = ZC_MOD_MUL * nzc;
        xfers = 0;
        dones = 0;
        @(posedge sys_clk); #1;
        zc_N_zc = LW'(nzc);
        zc_Q    = 15'(q);
        zc_P    = PW'(p);
        seq_len = LW'(len);
        start   = 1'b1;
        @(posedge sys_clk); #1;
        start   = 1'b0;
        // scramble config: only the latched copies may matter
        zc_N_zc = 11'd7;
        zc_Q    = 15'd13;
        zc_P    = 16'd3;
        seq_len = 11'd2047;
        chk("busy_after_start", busy, 1);
        chk("valid_in_init", phase_valid, 0);
        @(posedge sys_clk); #1;
        chk("first_valid_latency", phase_valid, 1);
        seen = 1'b0;
        for (int cyc = 0; cyc < len * 4 + 50; cyc++) begin
            if (poke && cyc == 2) start = 1'b1;
            if (poke && cyc == 3) start = 1'b0;
            @(posedge sys_clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("xfer_count", xfers, len);
        chk("busy_low_at_done", busy, 0);
        chk("valid_low_at_done", phase_valid, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        if (start_on_done) start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        chk("done_pulse_width", done, 0);
        chk("idle_after_done", busy, 0);
        chk("done_count", dones, 1);
        exp_q.delete();
    endtask

    initial begin
        int seqa[];
        int q_r, p_r, nz;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_phase", phase, 0);
        chk("rst_valid", phase_valid, 0);
        rst_n = 1'b1;

        // Nzc=5, Q=12, P=0, 12 samples: ZC term wraps twice
`ifdef RX_ZC_CONJ_EN
        seqa = '{0, 96, 48, 96, 0, 0, 96, 48, 96, 0, 0, 96};
`else
        seqa = '{0, 24, 72, 24, 0, 0, 24, 72, 24, 0, 0, 24};
`endif
        push_vec(seqa);
        run(5, 12, 0, 12, 1'b0, 1'b0, 1'b1);

        // Nzc=5, Q=12, P=10
`ifdef RX_ZC_CONJ_EN
        seqa = '{0, 86, 28, 66, 80, 70};
`else
        seqa = '{0, 34, 92, 54, 40, 50};
`endif
        push_vec(seqa);
        run(5, 12, 10, 6, 1'b0, 1'b0, 1'b0);

        // Nzc=1: pure cyclic-shift ramp mod 24
`ifdef RX_ZC_CONJ_EN
        seqa = '{0, 19, 14, 9, 4, 23};
`else
        seqa = '{0, 5, 10, 15, 20, 1};
`endif
        push_vec(seqa);
        run(1, 12, 5, 6, 1'b0, 1'b0, 1'b0);

        // same P=10 case with random back-pressure and a start while busy
`ifdef RX_ZC_CONJ_EN
        seqa = '{0, 86, 28, 66, 80, 70};
`else
        seqa = '{0, 34, 92, 54, 40, 50};
`endif
        push_vec(seqa);
        run(5, 12, 10, 6, 1'b1, 1'b1, 1'b0);

        // reset in the middle of a run, while sample 3 is presented
        rand_ready = 1'b0;
        cur_m = 120;
        xfers = 0;
        dones = 0;
        seqa = '{seqa[0], seqa[1], seqa[2]};
        push_vec(seqa);
        @(posedge sys_clk); #1;
        zc_N_zc = 11'd5; zc_Q = 15'd12; zc_P = 16'd10; seq_len = 11'd6;
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && xfers < 3; cyc++) @(negedge sys_clk);
        chk("abort_reached_sample3", xfers, 3);
        @(posedge sys_clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_phase", phase, 0);
        chk("abort_valid", phase_valid, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("abort_no_done", dones, 0);
        chk("abort_scoreboard", exp_q.size(), 0);
        exp_q.delete();

        // normal run after the abort
        seqa = '{};
`ifdef RX_ZC_CONJ_EN
        seqa = '{0, 86, 28, 66, 80, 70};
`else
        seqa = '{0, 34, 92, 54, 40, 50};
`endif
        push_vec(seqa);
        run(5, 12, 10, 6, 1'b0, 1'b0, 1'b0);

        // Nzc=2039, random Q and P, 2047 samples against the closed form
        nz  = 2039;
        q_r = (12 * int'($urandom_range(1, 2038))) % (ZC_MOD_MUL * nz);
        p_r = int'($urandom_range(0, ZC_MOD_MUL * nz - 1));
        for (int n = 0; n < 2047; n++) exp_q.push_back(PW'(model(n, nz, q_r, p_r)));
        run(nz, q_r, p_r, 2047, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
